uart_rx_framed: RTL

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx_framed.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions for the receiver and transmitter.
// Frame geometry, line levels and the 3-bit FSM state encodings.
// No storage; constants and helpers only.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;
   localparam logic UART_IDLE_LEVEL = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

   typedef logic [2:0] uart_state_t;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_STOP    = 3'd3;
   localparam logic [2:0] ST_CLEANUP = 3'd4;

   // Counter value at the centre of the start bit, measured from its detection.
   function automatic logic [7:0] uart_mid_count(input int clks_per_bit);
      return 8'((clks_per_bit - 1) / 2);
   endfunction

   function automatic logic [7:0] uart_last_count(input int clks_per_bit);
      return 8'(clks_per_bit - 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset level.
// Latency: 2 clocks. No backpressure.
// Both stages reset to RST_VAL so a quiet line reads as its idle level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver with glitch rejection on the start bit and stop-bit framing check.
// Latency: byte valid one clock after the mid stop-bit sample.
// No backpressure: o_Rx_DV / o_Frame_Err are single-cycle pulses that must be consumed.
module uart_rx_framed
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Busy,
   output logic       o_Frame_Err
);

   localparam logic [7:0] MID_CNT  = uart_mid_count(CLKS_PER_BIT);
   localparam logic [7:0] LAST_CNT = uart_last_count(CLKS_PER_BIT);
   localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

   logic rx_sync;

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] byte_q, byte_d;
   logic       dv_q, dv_d;
   logic       ferr_q, ferr_d;
   logic       busy_q, busy_d;

   sync_2ff #(
      .RST_VAL (UART_IDLE_LEVEL)
   ) u_sync (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_d     (i_Rx_Serial),
      .o_q     (rx_sync)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      busy_d  = busy_q;
      dv_d    = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = 8'd0;
            idx_d = 3'd0;
            if (rx_sync == UART_START_LEVEL) begin
               state_d = ST_START;
               busy_d  = 1'b1;
            end
         end

         ST_START: begin
            if (cnt_q == MID_CNT) begin
               cnt_d = 8'd0;
               // A line that is high again at mid start-bit was only a glitch.
               if (rx_sync == UART_START_LEVEL) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d          = 8'd0;
               shift_d[idx_q] = rx_sync;
               if (idx_q == LAST_IDX) begin
                  idx_d   = 3'd0;
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = 8'd0;
               state_d = ST_CLEANUP;
               // A bad stop bit leaves the last good byte on o_Rx_Byte.
               if (rx_sync == UART_IDLE_LEVEL) begin
                  byte_d = shift_q;
                  dv_d   = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_CLEANUP: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            idx_d   = 3'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= 3'd0;
         shift_q <= 8'd0;
         byte_q  <= 8'd0;
         dv_q    <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         dv_q    <= dv_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign o_Rx_DV     = dv_q;
   assign o_Rx_Byte   = byte_q;
   assign o_Rx_Busy   = busy_q;
   assign o_Frame_Err = ferr_q;

endmodule
